// File: rtl/fixed_max_pool2d_if.sv
// Stream interface for one side of the max-pool stage: one pixel of PAR
// signed channels per beat.
//
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// The master holds data and valid stable while valid && !ready. The slave
// may drive ready independently of valid.
interface fixed_max_pool2d_if #(
   parameter int DATA_WIDTH = 16,
   parameter int PAR        = 2
);
   logic [PAR-1:0][DATA_WIDTH-1:0] data;
   logic                           valid;
   logic                           ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fixed_max_pool2d.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered pixel stream.
// Even columns park the pixel in a hold register, odd columns fold it into a
// horizontal max. Even rows store that max in a half-width line buffer, odd
// rows combine it with the stored max and load the output register.
// A trailing odd column or row is accepted but never produces a result.
module fixed_max_pool2d #(
   parameter int DATA_WIDTH = 16,
   parameter int PAR        = 2,
   parameter int IMG_WIDTH  = 4,
   parameter int IMG_HEIGHT = 4
) (
   input  logic             clk,
   input  logic             rst,
   fixed_max_pool2d_if.slave  in_if,
   fixed_max_pool2d_if.master out_if
);
   localparam int LB_DEPTH = IMG_WIDTH / 2;
   localparam int CW       = $clog2(IMG_WIDTH);
   localparam int RW       = $clog2(IMG_HEIGHT);
   localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   typedef logic [PAR-1:0][DATA_WIDTH-1:0] pix_t;

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   pix_t           hold_q;
   pix_t           h_max;
   pix_t           pool_max;
   pix_t           lb_rd;
   pix_t           out_data_q;
   pix_t           line_buf [LB_DEPTH];
   logic           out_valid_q;
   logic           in_ready;
   logic           accept;
   logic           odd_col;
   logic           odd_row;
   logic           load_out;
   logic [LBW-1:0] lb_idx;

   // A new beat may enter whenever the output register is free or draining
   // this cycle; this never looks at in_if.valid.
   assign in_ready = !out_valid_q || out_if.ready;
   assign accept   = in_if.valid && in_ready;
   assign odd_col  = col[0];
   assign odd_row  = row[0];
   assign lb_idx   = LBW'(col >> 1);
   assign lb_rd    = line_buf[lb_idx];
   // Only the bottom-right pixel of a complete window loads a result.
   assign load_out = accept && odd_col && odd_row;

   assign in_if.ready  = in_ready;
   assign out_if.data  = out_data_q;
   assign out_if.valid = out_valid_q;

   // Per-channel signed maxima: horizontal pair, then against the row above.
   always_comb begin
      h_max    = '0;
      pool_max = '0;
      for (int ch = 0; ch < PAR; ch++) begin
         h_max[ch]    = ($signed(in_if.data[ch]) > $signed(hold_q[ch]))
                        ? in_if.data[ch] : hold_q[ch];
         pool_max[ch] = ($signed(lb_rd[ch]) > $signed(h_max[ch]))
                        ? lb_rd[ch] : h_max[ch];
      end
   end

   // Raster position of the next accepted beat; wraps into the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Left pixel of each horizontal pair waits here for its partner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else if (accept && !odd_col) begin
         hold_q <= in_if.data;
      end
   end

   // Horizontal maxima of the top row of each window; written before read.
   always_ff @(posedge clk) begin
      if (accept && odd_col && !odd_row) begin
         line_buf[lb_idx] <= h_max;
      end
   end

   // Output register: a new result overrides a same-cycle drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (load_out) begin
         out_valid_q <= 1'b1;
         out_data_q  <= pool_max;
      end else if (out_if.ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fixed_max_pool2d.sv
// Bench for fixed_max_pool2d: a 4x4 instance and a 5x5 instance, both PAR=2.
// Expected pooled pixels come from a window-max model over the whole frame.
module tb_fixed_max_pool2d;
   localparam int DW  = 16;
   localparam int PAR = 2;
   localparam int AW  = 4;
   localparam int AH  = 4;
   localparam int BW  = 5;
   localparam int BH  = 5;

   typedef logic [PAR-1:0][DW-1:0] pix_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fixed_max_pool2d_if #(.DATA_WIDTH(DW), .PAR(PAR)) a_in ();
   fixed_max_pool2d_if #(.DATA_WIDTH(DW), .PAR(PAR)) a_out ();
   fixed_max_pool2d_if #(.DATA_WIDTH(DW), .PAR(PAR)) b_in ();
   fixed_max_pool2d_if #(.DATA_WIDTH(DW), .PAR(PAR)) b_out ();

   fixed_max_pool2d #(.DATA_WIDTH(DW), .PAR(PAR), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .in_if  (a_in),
      .out_if (a_out)
   );

   fixed_max_pool2d #(.DATA_WIDTH(DW), .PAR(PAR), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
      .clk    (clk),
      .rst    (rst),
      .in_if  (b_in),
      .out_if (b_out)
   );

   // ---------------- scoreboard state ----------------
   pix_t exp_a[$];
   pix_t exp_b[$];
   pix_t img [BW*BH];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   idx_a, idx_b;    // linear raster index of the next beat in each frame
   bit   ev_a, ev_b;      // model of output-valid
   bit   a_fire, b_fire;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit win_done(int idx, int w, int h);
      int r, c;
      r = idx / w;
      c = idx % w;
      return (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
   endfunction

   // Queue the max of every 2x2 window whose last pixel is among the first nbeats.
   task automatic model_push(int which, int w, int h, int nbeats);
      for (int r2 = 0; r2 < h / 2; r2++) begin
         for (int c2 = 0; c2 < w / 2; c2++) begin
            if ((2 * r2 + 1) * w + 2 * c2 + 1 < nbeats) begin
               pix_t o;
               for (int ch = 0; ch < PAR; ch++) begin
                  int m;
                  m = -(1 << 30);
                  for (int dr = 0; dr < 2; dr++) begin
                     for (int dc = 0; dc < 2; dc++) begin
                        logic signed [DW-1:0] v;
                        int vi;
                        v  = img[(2 * r2 + dr) * w + 2 * c2 + dc][ch];
                        vi = v;
                        if (vi > m) m = vi;
                     end
                  end
                  o[ch] = DW'(m);
               end
               if (which == 0) exp_a.push_back(o);
               else exp_b.push_back(o);
            end
         end
      end
   endtask

   task automatic fill_img(int n, bit ramp);
      for (int k = 0; k < n; k++) begin
         img[k][0] = ramp ? DW'(k) : DW'($urandom);
         img[k][1] = DW'($urandom);
      end
   endtask

   // ---------------- driver: one clock cycle with full checking ----------------
   task automatic cycle();
      bit done;
      @(negedge clk);
      check("a_out_valid", 64'(a_out.valid), 64'(ev_a));
      check("a_in_ready", 64'(a_in.ready), 64'(!ev_a || a_out.ready));
      if (a_out.valid && a_out.ready) begin
         check("a_out_expected", 64'(exp_a.size() != 0), 64'(1));
         if (exp_a.size() != 0) check("a_out_data", 64'(a_out.data), 64'(exp_a.pop_front()));
      end
      a_fire = a_in.valid && a_in.ready;
      done   = a_fire && win_done(idx_a, AW, AH);
      ev_a   = done || (ev_a && !a_out.ready);
      if (a_fire) idx_a = (idx_a + 1) % (AW * AH);

      check("b_out_valid", 64'(b_out.valid), 64'(ev_b));
      check("b_in_ready", 64'(b_in.ready), 64'(!ev_b || b_out.ready));
      if (b_out.valid && b_out.ready) begin
         check("b_out_expected", 64'(exp_b.size() != 0), 64'(1));
         if (exp_b.size() != 0) check("b_out_data", 64'(b_out.data), 64'(exp_b.pop_front()));
      end
      b_fire = b_in.valid && b_in.ready;
      done   = b_fire && win_done(idx_b, BW, BH);
      ev_b   = done || (ev_b && !b_out.ready);
      if (b_fire) idx_b = (idx_b + 1) % (BW * BH);
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(int which, int from, int to, int vprob, int rprob);
      for (int k = from; k < to; k++) begin
         int tries;
         bit fired;
         tries = 0;
         fired = 0;
         if (which == 0) a_in.data = img[k];
         else b_in.data = img[k];
         do begin
            if (which == 0) begin
               a_in.valid  = ($urandom_range(99) < vprob);
               a_out.ready = ($urandom_range(99) < rprob);
            end else begin
               b_in.valid  = ($urandom_range(99) < vprob);
               b_out.ready = ($urandom_range(99) < rprob);
            end
            cycle();
            tries++;
            fired = (which == 0) ? a_fire : b_fire;
         end while (!fired && tries < 200);
         check("beat_accepted", 64'(fired), 64'(1));
      end
      a_in.valid = 1'b0;
      b_in.valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      a_in.valid  = 1'b0;
      b_in.valid  = 1'b0;
      a_out.ready = 1'b1;
      b_out.ready = 1'b1;
      while ((exp_a.size() != 0 || exp_b.size() != 0 || ev_a || ev_b) && n < 50) begin
         cycle();
         n++;
      end
      check("a_queue_empty", 64'(exp_a.size()), 64'(0));
      check("b_queue_empty", 64'(exp_b.size()), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      check("rst_a_valid", 64'(a_out.valid), 64'(0));
      check("rst_a_data", 64'(a_out.data), 64'(0));
      check("rst_a_in_ready", 64'(a_in.ready), 64'(1));
      check("rst_b_valid", 64'(b_out.valid), 64'(0));
      check("rst_b_data", 64'(b_out.data), 64'(0));
      exp_a.delete();
      exp_b.delete();
      ev_a  = 0;
      ev_b  = 0;
      idx_a = 0;
      idx_b = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst         = 1'b0;
      a_in.valid  = 1'b0;
      a_in.data   = '0;
      a_out.ready = 1'b1;
      b_in.valid  = 1'b0;
      b_in.data   = '0;
      b_out.ready = 1'b1;
      #1;
      do_reset();

      // Ramp frame on ch0 at full throughput: outputs 5,7,13,15.
      fill_img(AW * AH, 1'b1);
      model_push(0, AW, AH, AW * AH);
      send_beats(0, 0, AW * AH, 100, 100);
      drain();

      // Signed compare and channel independence on the first window.
      fill_img(AW * AH, 1'b0);
      img[0]      = {16'sd100, -16'sd3};
      img[1]      = {-16'sd100, -16'sd8};
      img[AW]     = {16'sd0, -16'sd1};
      img[AW + 1] = {16'sd99, -16'sd20};
      model_push(0, AW, AH, AW * AH);
      send_beats(0, 0, AW + 2, 100, 100);
      check("signed_ch0", 64'(a_out.data[0]), 64'(16'hFFFF));
      check("signed_ch1", 64'(a_out.data[1]), 64'(16'd100));
      send_beats(0, AW + 2, AW * AH, 100, 100);
      drain();

      // Backpressure for 10 cycles right after the first result.
      fill_img(AW * AH, 1'b0);
      model_push(0, AW, AH, AW * AH);
      send_beats(0, 0, AW + 2, 100, 100);
      a_out.ready = 1'b0;
      a_in.valid  = 1'b1;
      a_in.data   = img[AW + 2];
      repeat (10) begin
         cycle();
         check("bp_hold_data", 64'(a_out.data), 64'(exp_a[0]));
         check("bp_no_accept", 64'(a_fire), 64'(0));
      end
      send_beats(0, AW + 2, AW * AH, 100, 100);
      drain();

      // Three back-to-back random frames with 50% valid and ready.
      for (int f = 0; f < 3; f++) begin
         fill_img(AW * AH, 1'b0);
         model_push(0, AW, AH, AW * AH);
         send_beats(0, 0, AW * AH, 50, 50);
      end
      drain();

      // Odd-sized 5x5 frame: last row/column dropped, outputs 6,8,16,18.
      fill_img(BW * BH, 1'b1);
      model_push(1, BW, BH, BW * BH);
      send_beats(1, 0, BW * BH, 100, 100);
      drain();
      check("b_frame_wrapped", 64'(idx_b), 64'(0));

      // Reset mid-frame after 6 beats, then a fresh ramp frame.
      fill_img(AW * AH, 1'b1);
      model_push(0, AW, AH, 6);
      send_beats(0, 0, 6, 100, 100);
      cycle();
      do_reset();
      fill_img(AW * AH, 1'b1);
      model_push(0, AW, AH, AW * AH);
      send_beats(0, 0, AW * AH, 100, 100);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
